fp32_fadd: RTL and testbench
============================

# fp32_fadd

Single-precision (IEEE-754 binary32) floating-point adder for the FPU datapath. Each clock it takes two operands and registers their rounded sum one cycle later. Every cycle starts a new, independent operation. It is used as the add/subtract primitive; subtraction is done upstream by flipping the sign bit of `x2`.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `x1`  in  32  operand A, binary32
- `x2`  in  32  operand B, binary32
- `y`  out  32  registered sum `x1 + x2`, binary32
- Internal net `big` (kept by name for waveform probing): 1 when |x1| >= |x2|, comparing {exponent, mantissa}; 0 otherwise.

## Operation
- Unpack each operand into sign, 8-bit exponent and 23-bit mantissa.
  - Exponent 0 is treated as zero; subnormal inputs are flushed to signed zero.
  - Otherwise prepend the hidden 1 to the mantissa.
- Use `big` to pick the larger-magnitude operand L and the smaller S.
  - Result sign = sign(L).
  - Alignment shift = exp(L) - exp(S).
  - If the shift is >= 26, S contributes only to sticky.
- Align S right, keeping guard, round and sticky bits (sticky = OR of all bits shifted past round).
- Magnitude path:
  - Same signs: add the significands; on carry-out, shift right 1 and increment the exponent.
  - Different signs: subtract S from L; left-normalize with a leading-zero count and decrement the exponent by that count.
- Rounding: round-to-nearest-even on guard/round/sticky. A rounding carry renormalizes (mantissa becomes 0, exponent +1).
- Exact cancellation (zero magnitude) gives +0.
- If both inputs are zero, the result is -0 only when both are -0; otherwise +0.
- Underflow: a normalized exponent <= 0 flushes to signed zero.
- Overflow: a final exponent >= 255 gives ±Inf (0x7F800000 with sign).
- Special inputs:
  - Any NaN input gives canonical qNaN 0x7FC00000.
  - +Inf + -Inf gives 0x7FC00000.
  - Inf + finite gives that Inf.
- No exception flags are produced.

## Timing
- All arithmetic is combinational from `x1`/`x2`, feeding a single output register on `y`.
- Latency is 1 cycle: operands present before rising edge N appear on `y` after edge N.
- Throughput is one operation per cycle. There is no handshake and no valid signal; operands may change every cycle.
- `rst` high forces `y` = 0x00000000 immediately, independent of `clk`, and holds it while asserted.
- The first result after `rst` deasserts is the one for the operands present at the next rising edge.
- Inputs that are X or undriven before reset release give undefined combinational results; `y` stays 0 while in reset.
- The combinational path must meet a 10 ns clock period target.

## Test plan
- Cancellation and zero: 0x40400000 + 0xC0400000 -> 0x00000000; 0x00000000 + 0x00000000 -> 0x00000000; each observed one cycle after its operands are applied.
- Mixed sign, different exponents: 0x40400000 (3) + 0xC37F0000 (-255) -> 0xC37C0000 (-252); `big` = 0.
- Carry-out with ties-to-even:
  - 0x4048F5C3 + 0x40000000 -> 0x40A47AE2 (tie, rounds up to even).
  - 0x3F800000 + 0x3F8CCCCD -> 0x40066666 (tie, stays even).
  - 0x40200000 + 0x40000000 -> 0x40900000.
- Huge exponent gap: 0x375C5184 + 0x609614A8 -> 0x609614A8 (small operand lost below half-ulp); `big` = 0.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x00400000 (subnormal) + 0x00000000 -> 0x00000000.
- Reset and pipelining:
  - Apply back-to-back operand pairs each cycle; verify `y` tracks each pair with exactly 1-cycle lag.
  - Assert `rst` mid-stream between clock edges; verify `y` = 0 immediately.
  - After deassert, verify the next edge's result is correct.

Source files
------------

// File: rtl/fp32_fadd.sv
// IEEE-754 binary32 adder, round-to-nearest-even, subnormals flushed, no flags.
// Latency 1 cycle, one new operation every cycle; no handshake and no backpressure.
module fp32_fadd (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);
    logic        s1, s2;
    logic [7:0]  e1, e2;
    logic [22:0] m1, m2;
    logic        z1, z2, inf1, inf2, nan1, nan2;
    logic        big;

    logic               sl, ss;
    logic [7:0]         el, es, sh;
    logic [23:0]        sigl, sigs;
    logic [49:0]        ext;
    logic [26:0]        lx, sx, diff, nrm;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [9:0]  en, ef;
    logic               up;
    logic [24:0]        rnd;
    logic [31:0]        res;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    assign {s1, e1, m1} = x1;
    assign {s2, e2, m2} = x2;
    assign z1   = (e1 == 8'd0);
    assign z2   = (e2 == 8'd0);
    assign inf1 = (e1 == 8'hFF) && (m1 == 23'd0);
    assign inf2 = (e2 == 8'hFF) && (m2 == 23'd0);
    assign nan1 = (e1 == 8'hFF) && (m1 != 23'd0);
    assign nan2 = (e2 == 8'hFF) && (m2 != 23'd0);
    assign big  = ({e1, m1} >= {e2, m2});

    always_comb begin
        sl   = big ? s1 : s2;
        ss   = big ? s2 : s1;
        el   = big ? e1 : e2;
        es   = big ? e2 : e1;
        sigl = big ? (z1 ? 24'd0 : {1'b1, m1}) : (z2 ? 24'd0 : {1'b1, m2});
        sigs = big ? (z2 ? 24'd0 : {1'b1, m2}) : (z1 ? 24'd0 : {1'b1, m1});
        sh   = el - es;

        // Significand | guard | round | sticky; bits below round collapse into sticky.
        ext = {sigs, 26'd0} >> sh;
        if (sh >= 8'd26)
            sx = {26'd0, |sigs};
        else
            sx = {ext[49:24], |ext[23:0]};
        lx   = {sigl, 3'b000};
        sum  = {1'b0, lx} + {1'b0, sx};
        diff = lx - sx;
        lz   = lzc27(diff);

        if (sl == ss) begin
            if (sum[27]) begin
                nrm = {sum[27:2], sum[1] | sum[0]};
                en  = $signed({2'b00, el}) + 10'sd1;
            end else begin
                nrm = sum[26:0];
                en  = $signed({2'b00, el});
            end
        end else begin
            nrm = diff << lz;
            en  = $signed({2'b00, el}) - $signed({5'd0, lz});
        end

        up  = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        rnd = {1'b0, nrm[26:3]} + {24'd0, up};
        // Hidden bit (weight 1) or rounding carry-out (weight 2) folds into the exponent.
        ef  = en + $signed({8'd0, rnd[24:23]}) - 10'sd1;

        res = {sl, ef[7:0], rnd[22:0]};
        if (nan1 || nan2 || (inf1 && inf2 && (s1 != s2)))
            res = 32'h7FC0_0000;
        else if (inf1)
            res = {s1, 31'h7F80_0000};
        else if (inf2)
            res = {s2, 31'h7F80_0000};
        else if (z1 && z2)
            res = {s1 & s2, 31'd0};
        else if ((sl != ss) && (diff == 27'd0))
            res = 32'h0000_0000;
        else if (en <= 10'sd0)
            res = {sl, 31'd0};
        else if (ef >= 10'sd255)
            res = {sl, 31'h7F80_0000};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            y <= 32'h0000_0000;
        else
            y <= res;
    end
endmodule

// File: tb/tb_fp32_fadd.sv
// Directed bench for fp32_fadd: scoreboard of hand-computed sums checked one cycle after issue.
module tb_fp32_fadd;
    logic        clk;
    logic        rst;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] prev;

    fp32_fadd dut (
        .clk (clk),
        .rst (rst),
        .x1  (x1),
        .x2  (x2),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Drive at the falling edge, confirm y still shows the previous result, then compare after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input string tag);
        logic [31:0] want;
        string       t;
        @(negedge clk);
        x1 = a;
        x2 = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        check({tag, "_hold"}, y, prev);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb_empty: got none want one", tag);
        end else begin
            want = exp_q.pop_front();
            t    = tag_q.pop_front();
            check(t, y, want);
            prev = want;
        end
    endtask

    initial begin
        rst  = 1'b1;
        x1   = 32'h0;
        x2   = 32'h0;
        prev = 32'h0;
        #12;
        check("reset_y", y, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        step(32'h4040_0000, 32'hC040_0000, 32'h0000_0000, "cancel");
        step(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zero_zero");
        step(32'h4040_0000, 32'hC37F_0000, 32'hC37C_0000, "mixed_sign");
        check("big_mixed", {31'd0, dut.big}, 32'd0);
        step(32'h4048_F5C3, 32'h4000_0000, 32'h40A4_7AE2, "tie_up");
        step(32'h3F80_0000, 32'h3F8C_CCCD, 32'h4006_6666, "tie_even");
        step(32'h4020_0000, 32'h4000_0000, 32'h4090_0000, "carry");
        step(32'h375C_5184, 32'h6096_14A8, 32'h6096_14A8, "huge_gap");
        check("big_gap", {31'd0, dut.big}, 32'd0);
        step(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow");
        step(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");
        step(32'h0040_0000, 32'h0000_0000, 32'h0000_0000, "subnormal");
        step(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "one_plus_one");
        check("big_equal", {31'd0, dut.big}, 32'd1);
        step(32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000, "one_minus_half");
        step(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "negz_negz");
        step(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, "negz_posz");
        step(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
        step(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "inf_finite");
        step(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "half_ulp_even");
        step(32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, "above_half_ulp");
        step(32'h0080_0000, 32'h8080_0001, 32'h8000_0000, "underflow");
        step(32'h3FFF_FFFF, 32'h3380_0000, 32'h4000_0000, "round_carry");
        step(32'h7F7F_FFFF, 32'h7300_0000, 32'h7F80_0000, "round_overflow");
        step(32'h4040_0000, 32'hC37F_0000, 32'hC37C_0000, "pre_reset");

        // Reset between edges must clear y at once and hold it across an edge.
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", y, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rst_hold", y, 32'h0000_0000);
        #1;
        rst  = 1'b0;
        prev = 32'h0000_0000;
        step(32'h4020_0000, 32'h4000_0000, 32'h4090_0000, "post_reset");
        step(32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000, "post_reset2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
